fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS-lite pipeline, directly upstream of the IF/ID pipeline register. Owns the PC and issues one outstanding request at a time to a variable-latency instruction memory. Buffers a returned word while the pipeline is stalled, discards in-flight responses on branch/jump redirect, and presents each fetched instruction with its PC+4 on a valid/stall handshake.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: datapath width, reset values
// and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int LENGTH = 32;

    // Value loaded into the hold buffer on reset.
    localparam logic [LENGTH-1:0] INITIAL_VAL = '0;

    // Default fetch address after reset.
    localparam logic [LENGTH-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // S_REQ  : ready to issue a request at pc
    // S_WAIT : one request outstanding, waiting for imem_rvalid
    // S_HOLD : response captured in hold_instr while downstream stalls
    // S_DROP : a stale response is still in flight after a redirect
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, keeps at most one request in
// flight to a variable-latency instruction memory, buffers a returned word
// while the pipeline stalls and discards in-flight data on redirect.
//
// Handshake: an instruction moves downstream on a cycle where
// valid_out=1 and stall=0 (ready = ~stall). valid_out never depends on
// stall, and instruction_out/pc_4_out stay stable while valid_out=1 and
// stall=1. A redirect cancels any transfer in the same cycle.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [LENGTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [LENGTH-1:0] redirect_target,
    output logic              imem_req,
    output logic [LENGTH-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [LENGTH-1:0] imem_rdata,
    output logic              valid_out,
    output logic [LENGTH-1:0] instruction_out,
    output logic [LENGTH-1:0] pc_4_out,
    output state_t            state_dbg
);

    state_t            state, state_n;
    logic [LENGTH-1:0] pc, pc_n;
    logic [LENGTH-1:0] hold_instr, hold_n;
    logic [LENGTH-1:0] pc_plus4;
    logic              transfer;

    // Wraps modulo 2^LENGTH; no special case at the top of memory.
    assign pc_plus4  = pc + 32'd4;
    assign state_dbg = state;

    // State, PC and hold buffer; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            hold_instr <= INITIAL_VAL;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            hold_instr <= hold_n;
        end
    end

    // Next-state logic and combinational outputs.
    always_comb begin
        state_n         = state;
        pc_n            = pc;
        hold_n          = hold_instr;
        valid_out       = 1'b0;
        instruction_out = '0;
        pc_4_out        = '0;
        transfer        = 1'b0;
        imem_req        = 1'b0;
        imem_addr       = (state == S_REQ) ? pc : pc_plus4;

        // Outputs are forced quiet while reset is held, even though the
        // registers already sit in S_REQ.
        if (!rst && !redirect) begin
            valid_out = ((state == S_WAIT) && imem_rvalid) || (state == S_HOLD);
        end
        transfer = valid_out && !stall;
        if (valid_out) begin
            instruction_out = (state == S_HOLD) ? hold_instr : imem_rdata;
            pc_4_out        = pc_plus4;
        end
        imem_req = !rst && !redirect && ((state == S_REQ) || transfer);

        if (redirect) begin
            pc_n = redirect_target;
            case (state)
                S_REQ:   state_n = S_REQ;
                S_WAIT:  state_n = imem_rvalid ? S_REQ : S_DROP;
                S_HOLD:  state_n = S_REQ;
                S_DROP:  state_n = imem_rvalid ? S_REQ : S_DROP;
                default: state_n = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: state_n = S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid && !stall) begin
                        pc_n = pc_plus4;
                    end else if (imem_rvalid) begin
                        hold_n  = imem_rdata;
                        state_n = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        pc_n    = pc_plus4;
                        state_n = S_WAIT;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) state_n = S_REQ;
                end
                default: state_n = S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the memory side is driven by hand, cycle
// by cycle, and every output is compared against hand-computed values.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall = 1'b0;
    logic              redirect = 1'b0;
    logic [LENGTH-1:0] redirect_target = '0;
    logic              imem_req;
    logic [LENGTH-1:0] imem_addr;
    logic              imem_rvalid = 1'b0;
    logic [LENGTH-1:0] imem_rdata = '0;
    logic              valid_out;
    logic [LENGTH-1:0] instruction_out;
    logic [LENGTH-1:0] pc_4_out;
    state_t            state_dbg;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .valid_out       (valid_out),
        .instruction_out (instruction_out),
        .pc_4_out        (pc_4_out),
        .state_dbg       (state_dbg)
    );

    // Clock: posedges at 5, 15, 25 ...; inputs change on negedges.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge, apply inputs, let combinational logic settle.
    task automatic cyc(input logic st, input logic rd, input logic [31:0] tgt,
                       input logic rv, input logic [31:0] rdat);
        @(negedge clk);
        stall           = st;
        redirect        = rd;
        redirect_target = tgt;
        imem_rvalid     = rv;
        imem_rdata      = rdat;
        #1;
    endtask

    // Compare the full output set; imem_addr only matters when a request is expected.
    task automatic outs(input string tag, input logic req, input logic [31:0] addr,
                        input logic vld, input logic [31:0] instr, input logic [31:0] pc4);
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, vld});
        chk({tag, ".instr"}, instruction_out, instr);
        chk({tag, ".pc4"}, pc_4_out, pc4);
    endtask

    task automatic st_chk(input string tag, input state_t exp);
        chk({tag, ".state"}, {30'd0, state_dbg}, {30'd0, exp});
    endtask

    initial begin
        // Reset held across a few edges with the memory idle.
        repeat (2) @(posedge clk);
        #1;
        outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        st_chk("reset", S_REQ);

        // Release reset; first request goes to RESET_PC in this cycle.
        @(negedge clk);
        rst = 1'b0;
        #1;
        outs("first_req", 1'b1, 32'h0000_3000, 1'b0, 32'h0, 32'h0);

        // Single-cycle memory, no stall: one instruction per cycle.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_0000);
        outs("stream0", 1'b1, 32'h0000_3004, 1'b1, 32'h1111_0000, 32'h0000_3004);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_0001);
        outs("stream1", 1'b1, 32'h0000_3008, 1'b1, 32'h1111_0001, 32'h0000_3008);

        // Response arrives under stall: captured, no new request.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h2408_0001);
        outs("stall_rx", 1'b0, 32'h0, 1'b1, 32'h2408_0001, 32'h0000_300C);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, JUNK);
        st_chk("hold1", S_HOLD);
        outs("hold1", 1'b0, 32'h0, 1'b1, 32'h2408_0001, 32'h0000_300C);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, JUNK);
        outs("hold2", 1'b0, 32'h0, 1'b1, 32'h2408_0001, 32'h0000_300C);
        // Stall drops: transfer plus request at pc+4 in the same cycle.
        cyc(1'b0, 1'b0, 32'h0, 1'b0, JUNK);
        outs("hold_release", 1'b1, 32'h0000_300C, 1'b1, 32'h2408_0001, 32'h0000_300C);

        // Slow memory: redirect one cycle after the request to 0x300C.
        cyc(1'b0, 1'b1, 32'h0000_3100, 1'b0, JUNK);
        outs("redir_wait", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, JUNK);
        st_chk("drop1", S_DROP);
        outs("drop1", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, JUNK);
        outs("drop2", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        // Stale response (four cycles after its request) is swallowed.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
        outs("stale_rx", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, JUNK);
        outs("req_target", 1'b1, 32'h0000_3100, 1'b0, 32'h0, 32'h0);

        // Redirect in the same cycle as rvalid: no transfer, data dropped.
        cyc(1'b0, 1'b1, 32'h0000_3200, 1'b1, 32'h6666_6666);
        outs("redir_rvalid", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, JUNK);
        outs("req_3200", 1'b1, 32'h0000_3200, 1'b0, 32'h0, 32'h0);

        // Redirect while holding a stalled word: buffer discarded.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h7777_7777);
        outs("hold_again", 1'b0, 32'h0, 1'b1, 32'h7777_7777, 32'h0000_3204);
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, JUNK);
        outs("redir_hold", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, JUNK);
        outs("req_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);

        // Fetch at the top of the address space: pc+4 wraps to zero.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h8888_8888);
        outs("wrap", 1'b1, 32'h0000_0000, 1'b1, 32'h8888_8888, 32'h0000_0000);

        // Asynchronous reset in the middle of a cycle with a response pending.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h9999_9999);
        outs("pre_rst", 1'b1, 32'h0000_0004, 1'b1, 32'h9999_9999, 32'h0000_0004);
        #1;
        rst = 1'b1;
        #1;
        outs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        st_chk("async_rst", S_REQ);
        imem_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        outs("post_rst", 1'b1, 32'h0000_3000, 1'b0, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
